t03_sram_port_ctrl: RTL

//  Sequencer between the cache/memory request side and the t03 dual-port SRAM macro (port 0 write, port 1 read).

---
 rtl/t03_sram_port_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/t03_sram_port_ctrl.sv
// Request sequencer for the t03 dual-port SRAM macro (port 0 write, port 1 read).
// Registers active-low chip selects and returns captured read data on a valid/ready channel.
module t03_sram_port_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e                state_q, state_d;
    logic                  csb0_q, csb0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
    logic                  csb1_q, csb1_d;
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  fwd_hit_q, fwd_hit_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
    logic                  rd_accept;

    assign wr_ready  = 1'b1;
    assign rd_ready  = (state_q == IDLE) | ((state_q == RESP) & rsp_ready);
    assign rd_accept = rd_valid & rd_ready;
    assign busy      = (state_q != IDLE);

    assign sram_csb0  = csb0_q;
    assign sram_addr0 = addr0_q;
    assign sram_din0  = din0_q;
    assign sram_csb1  = csb1_q;
    assign sram_addr1 = addr1_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;

    always_comb begin
        state_d     = state_q;
        csb0_d      = ~wr_valid;
        addr0_d     = wr_valid ? wr_addr : addr0_q;
        din0_d      = wr_valid ? wr_data : din0_q;
        csb1_d      = 1'b1;
        addr1_d     = addr1_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        fwd_hit_d   = fwd_hit_q;
        fwd_data_d  = fwd_data_q;

        unique case (state_q)
            IDLE: begin
                if (rd_accept) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = fwd_hit_q ? fwd_data_q : sram_dout1;
                fwd_hit_d   = 1'b0;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = rd_accept ? ISSUE : IDLE;
                end
            end
        endcase

        // A same-edge write to the read address lands on the same negedge
        // as the array read, so its data is forwarded instead.
        if (rd_accept) begin
            csb1_d     = 1'b0;
            addr1_d    = rd_addr;
            fwd_hit_d  = wr_valid & (wr_addr == rd_addr);
            fwd_data_d = wr_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            csb0_q      <= 1'b1;
            addr0_q     <= '0;
            din0_q      <= '0;
            csb1_q      <= 1'b1;
            addr1_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            fwd_hit_q   <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            csb0_q      <= csb0_d;
            addr0_q     <= addr0_d;
            din0_q      <= din0_d;
            csb1_q      <= csb1_d;
            addr1_q     <= addr1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            fwd_hit_q   <= fwd_hit_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

endmodule
